// File: rtl/vga_sprite_engine.sv
`timescale 1ns/1ps
// VGA 640x480-style timing generator with a priority sprite compositor fed by a synchronous texel ROM.
// Colour and syncs leave three cycles after the raster counters.
module vga_sprite_engine #(
   parameter int         H_VISIBLE     = 640,
   parameter int         H_FP          = 16,
   parameter int         H_SYNC        = 96,
   parameter int         H_BP          = 48,
   parameter int         V_VISIBLE     = 480,
   parameter int         V_FP          = 10,
   parameter int         V_SYNC        = 2,
   parameter int         V_BP          = 33,
   parameter int         NUM_SPRITES   = 4,
   parameter int         SPR_W         = 32,
   parameter int         SPR_H         = 32,
   parameter int         SCALE_LOG2    = 3,
   parameter int         ANIM_DIV_LOG2 = 4,
   parameter logic [5:0] TRANSPARENT   = 6'b000000,
   parameter logic [5:0] BG_COLOR      = 6'b111000,
   parameter logic       SYNC_POL      = 1'b0,
   localparam int        IW            = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
   localparam int        AW            = IW + 1 + $clog2(SPR_H) + $clog2(SPR_W)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_we,
   input  logic [IW-1:0] cfg_sel,
   input  logic [10:0]   cfg_x,
   input  logic [9:0]    cfg_y,
   input  logic          cfg_en,
   output logic [AW-1:0] rom_addr,
   input  logic [5:0]    rom_data,
   output logic [7:0]    vga_pmod,
   output logic          frame_tick
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int XW      = $clog2(H_TOTAL);
   localparam int YW      = $clog2(V_TOTAL);
   localparam int RW      = $clog2(SPR_H);
   localparam int CW      = $clog2(SPR_W);

   localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
   localparam logic [XW-1:0] X_VIS  = XW'(H_VISIBLE);
   localparam logic [XW-1:0] HS_BEG = XW'(H_VISIBLE + H_FP);
   localparam logic [XW-1:0] HS_END = XW'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
   localparam logic [YW-1:0] Y_VIS  = YW'(V_VISIBLE);
   localparam logic [YW-1:0] VS_BEG = YW'(V_VISIBLE + V_FP);
   localparam logic [YW-1:0] VS_END = YW'(V_VISIBLE + V_FP + V_SYNC);

   localparam logic signed [11:0] SPAN_X = 12'(SPR_W << SCALE_LOG2);
   localparam logic signed [11:0] SPAN_Y = 12'(SPR_H << SCALE_LOG2);

   function automatic logic [5:0] pick_colour(input logic vis, input logic hit, input logic [5:0] tex);
      if (!vis) return 6'b000000;
      if (!hit || tex == TRANSPARENT) return BG_COLOR;
      return tex;
   endfunction

   function automatic logic [7:0] pack_pmod(input logic hs, input logic vs, input logic [5:0] c);
      return {hs, c[5], c[3], c[1], vs, c[4], c[2], c[0]};
   endfunction

   logic [XW-1:0]          x;
   logic [YW-1:0]          y;
   logic [ANIM_DIV_LOG2:0] anim_cnt;
   logic                   eol, eof;

   logic [10:0]            sh_x  [NUM_SPRITES];
   logic [9:0]             sh_y  [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] sh_en;
   logic [10:0]            act_x [NUM_SPRITES];
   logic [9:0]             act_y [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] act_en;

   logic signed [11:0]     dx [NUM_SPRITES];
   logic signed [11:0]     dy [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] hit_v;
   logic                   win_c, vis_c, hs_c, vs_c;
   logic [AW-1:0]          addr_c;

   logic hit_p0, vld_p0, hs_p0, vs_p0;
   logic hit_p1, vld_p1, hs_p1, vs_p1;

   assign eol = (x == X_LAST);
   assign eof = eol && (y == Y_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x          <= '0;
         y          <= '0;
         anim_cnt   <= '0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= eof;
         if (eol) begin
            x <= '0;
            y <= eof ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
         if (eof) anim_cnt <= anim_cnt + 1'b1;
      end
   end

   // Shadows take writes any time; the displayed set only changes on the frame wrap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_en  <= '0;
         act_en <= '0;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            sh_x[i]  <= '0;
            sh_y[i]  <= '0;
            act_x[i] <= '0;
            act_y[i] <= '0;
         end
      end else begin
         if (eof) begin
            act_en <= sh_en;
            for (int i = 0; i < NUM_SPRITES; i++) begin
               act_x[i] <= sh_x[i];
               act_y[i] <= sh_y[i];
            end
         end
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (cfg_we && cfg_sel == IW'(i)) begin
               sh_x[i]  <= cfg_x;
               sh_y[i]  <= cfg_y;
               sh_en[i] <= cfg_en;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
         dx[i]    = $signed(12'(x)) - $signed({1'b0, act_x[i]});
         dy[i]    = $signed(12'(y)) - $signed({2'b00, act_y[i]});
         hit_v[i] = act_en[i] && (dx[i] >= 12'sd0) && (dx[i] < SPAN_X) &&
                    (dy[i] >= 12'sd0) && (dy[i] < SPAN_Y);
      end
   end

   // Scan from the top index down so the lowest hitting index is the last one written.
   always_comb begin
      win_c  = 1'b0;
      addr_c = '0;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (hit_v[i]) begin
            win_c  = 1'b1;
            addr_c = {IW'(i), anim_cnt[ANIM_DIV_LOG2],
                      RW'($unsigned(dy[i]) >> SCALE_LOG2),
                      CW'($unsigned(dx[i]) >> SCALE_LOG2)};
         end
      end
      vis_c = (x < X_VIS) && (y < Y_VIS);
      hs_c  = (x >= HS_BEG && x < HS_END) ? SYNC_POL : ~SYNC_POL;
      vs_c  = (y >= VS_BEG && y < VS_END) ? SYNC_POL : ~SYNC_POL;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rom_addr <= '0;
         hit_p0   <= 1'b0;
         vld_p0   <= 1'b0;
         hs_p0    <= ~SYNC_POL;
         vs_p0    <= ~SYNC_POL;
         hit_p1   <= 1'b0;
         vld_p1   <= 1'b0;
         hs_p1    <= ~SYNC_POL;
         vs_p1    <= ~SYNC_POL;
         vga_pmod <= {~SYNC_POL, 3'b000, ~SYNC_POL, 3'b000};
      end else begin
         // p0: texel address issued to the ROM
         if (win_c) rom_addr <= addr_c;
         hit_p0 <= win_c;
         vld_p0 <= vis_c;
         hs_p0  <= hs_c;
         vs_p0  <= vs_c;
         // p1: ROM access in flight
         hit_p1 <= hit_p0;
         vld_p1 <= vld_p0;
         hs_p1  <= hs_p0;
         vs_p1  <= vs_p0;
         // p2: texel returned, final colour registered
         vga_pmod <= pack_pmod(hs_p1, vs_p1, pick_colour(vld_p1, hit_p1, rom_data));
      end
   end

endmodule

// File: tb/tb_vga_sprite_engine.sv
`timescale 1ns/1ps
// Randomised scoreboard bench for vga_sprite_engine on a shrunken raster (64x32 totals, 3 sprites).
module tb_vga_sprite_engine;

   localparam int HV = 48, HF = 4, HS = 6, HB = 6;
   localparam int VV = 24, VF = 2, VS = 2, VB = 4;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int N = 3, SW = 8, SH = 8, SC = 1, AD = 1;
   localparam int TEX = 1 << SC;
   localparam int SPAN_W = SW * TEX, SPAN_H = SH * TEX;
   localparam logic [5:0] TR = 6'b000000;
   localparam logic [5:0] BG = 6'b111000;
   localparam logic SP = 1'b0;
   localparam logic [7:0] RST_PMOD = {~SP, 3'b000, ~SP, 3'b000};

   logic        clk, rst_n, cfg_we, cfg_en, frame_tick;
   logic [1:0]  cfg_sel;
   logic [10:0] cfg_x;
   logic [9:0]  cfg_y;
   logic [8:0]  rom_addr;
   logic [5:0]  rom_data;
   logic [7:0]  vga_pmod;

   vga_sprite_engine #(
      .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .NUM_SPRITES(N), .SPR_W(SW), .SPR_H(SH), .SCALE_LOG2(SC), .ANIM_DIV_LOG2(AD),
      .TRANSPARENT(TR), .BG_COLOR(BG), .SYNC_POL(SP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_x(cfg_x),
      .cfg_y(cfg_y), .cfg_en(cfg_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .vga_pmod(vga_pmod), .frame_tick(frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Texel contents: sprite 0 has a transparent column every 4 texels, the rest is a hash.
   function automatic logic [5:0] rom_fn(input logic [8:0] a);
      logic [8:0] m;
      if (a[8:7] == 2'b00 && a[1:0] == 2'b00) return TR;
      m = (a * 9'd37) ^ (a >> 3);
      return m[5:0];
   endfunction

   always @(posedge clk) rom_data <= rom_fn(rom_addr);

   typedef struct { int due; logic [8:0] val; } ent_t;
   ent_t q_pmod[$], q_addr[$], q_tick[$];

   int n_tests = 0, n_fail = 0, cyc = 0;
   int mx, my, manim, mtick;
   int sh_x[N], sh_y[N], sh_en[N], ac_x[N], ac_y[N], ac_en[N];
   logic [8:0] m_last;

   function automatic void find_hit(input int x, input int y, input int anim,
                                    output int idx, output logic [8:0] addr);
      idx  = -1;
      addr = '0;
      for (int i = 0; i < N; i++) begin
         if (ac_en[i] != 0 && x >= ac_x[i] && x < ac_x[i] + SPAN_W &&
             y >= ac_y[i] && y < ac_y[i] + SPAN_H) begin
            idx  = i;
            addr = 9'(i * 128 + anim * 64 + ((y - ac_y[i]) / TEX) * 8 + (x - ac_x[i]) / TEX);
            return;
         end
      end
   endfunction

   function automatic logic [7:0] exp_pmod(input int x, input int y, input int anim);
      logic hs, vs;
      logic [5:0] c, t;
      logic [8:0] a;
      int idx;
      hs = (x >= HV + HF && x < HV + HF + HS) ? SP : ~SP;
      vs = (y >= VV + VF && y < VV + VF + VS) ? SP : ~SP;
      c  = 6'b000000;
      if (x < HV && y < VV) begin
         find_hit(x, y, anim, idx, a);
         if (idx < 0) c = BG;
         else begin
            t = rom_fn(a);
            c = (t == TR) ? BG : t;
         end
      end
      return {hs, c[5], c[3], c[1], vs, c[4], c[2], c[0]};
   endfunction

   // Reference model: advances one raster position per edge and queues the expected outputs.
   initial begin
      int idx;
      logic [8:0] a;
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) begin
            mx = 0; my = 0; manim = 0; mtick = 0; m_last = '0;
            for (int i = 0; i < N; i++) begin
               sh_x[i] = 0; sh_y[i] = 0; sh_en[i] = 0;
               ac_x[i] = 0; ac_y[i] = 0; ac_en[i] = 0;
            end
            q_pmod.delete(); q_addr.delete(); q_tick.delete();
            for (int k = 0; k < 3; k++) q_pmod.push_back('{cyc + k, 9'(RST_PMOD)});
            q_addr.push_back('{cyc, 9'd0});
         end else begin
            if (mx == HT - 1 && my == VT - 1) begin
               mx = 0; my = 0; mtick = 1;
               manim = (manim + 1) % (2 << AD);
               for (int i = 0; i < N; i++) begin
                  ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_en[i] = sh_en[i];
               end
            end else begin
               mtick = 0;
               if (mx == HT - 1) begin mx = 0; my++; end
               else mx++;
            end
            if (cfg_we && int'(cfg_sel) < N) begin
               sh_x[cfg_sel] = int'(cfg_x); sh_y[cfg_sel] = int'(cfg_y); sh_en[cfg_sel] = int'(cfg_en);
            end
         end
         q_pmod.push_back('{cyc + 3, 9'(exp_pmod(mx, my, manim >> AD)) });
         find_hit(mx, my, manim >> AD, idx, a);
         if (idx >= 0) m_last = a;
         q_addr.push_back('{cyc + 1, m_last});
         q_tick.push_back('{cyc, 9'(mtick)});
      end
   end

   task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
      end
   endtask

   // Monitor: every cycle the DUT presents pmod, rom_addr and frame_tick.
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         while (q_pmod.size() > 0 && q_pmod[0].due <= cyc) begin
            e = q_pmod.pop_front();
            if (e.due == cyc) check("pmod", 9'(vga_pmod), e.val);
         end
         while (q_addr.size() > 0 && q_addr[0].due <= cyc) begin
            e = q_addr.pop_front();
            if (e.due == cyc) check("rom_addr", rom_addr, e.val);
         end
         while (q_tick.size() > 0 && q_tick[0].due <= cyc) begin
            e = q_tick.pop_front();
            if (e.due == cyc) check("frame_tick", 9'(frame_tick), e.val);
         end
      end
   end

   task automatic wr(input int sel, input int x, input int y, input int en);
      cfg_we  = 1'b1;
      cfg_sel = 2'(sel);
      cfg_x   = 11'(x);
      cfg_y   = 10'(y);
      cfg_en  = (en != 0);
      @(negedge clk);
      cfg_we  = 1'b0;
   endtask

   task automatic wait_pos(input int x, input int y);
      int n = 0;
      while (!(mx == x && my == y)) begin
         @(negedge clk);
         n++;
         if (n > 2 * HT * VT) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_pos timeout got=(%0d,%0d) want=(%0d,%0d)", mx, my, x, y);
            return;
         end
      end
   endtask

   task automatic rand_wr();
      int x, y;
      x = ($urandom_range(0, 3) == 0) ? $urandom_range(2030, 2047) : $urandom_range(0, 70);
      y = ($urandom_range(0, 3) == 0) ? $urandom_range(1010, 1023) : $urandom_range(0, 40);
      wr($urandom_range(0, 3), x, y, ($urandom_range(0, 3) != 0) ? 1 : 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_x = '0; cfg_y = '0; cfg_en = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (HT * VT + 10) @(negedge clk);
      wr(0, 10, 5, 1);
      wr(1, 14, 7, 1);
      wr(2, 2040, 3, 1);
      wr(3, 0, 0, 1);
      wait_pos(20, 12);
      wr(0, 30, 10, 1);
      repeat (2 * HT * VT) @(negedge clk);
      wait_pos(HT - 1, VT - 1);
      wr(1, 40, 20, 1);
      wait_pos(0, 0);
      wr(2, 50, 1020, 1);
      repeat (HT * VT) @(negedge clk);
      repeat (40) begin
         repeat ($urandom_range(1, 500)) @(negedge clk);
         rand_wr();
      end
      wait_pos(30, 12);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wr(0, 5, 2, 1);
      wr(1, 8, 6, 1);
      wr(2, 2045, 1015, 1);
      repeat (5 * HT * VT) @(negedge clk);
      repeat (10) begin
         repeat ($urandom_range(1, 400)) @(negedge clk);
         rand_wr();
      end
      repeat (HT * VT) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_sprite_engine.md
VGA_SPRITE_ENGINE -- requirements
Module: vga_sprite_engine

Interface
REQ-001 SHALL have parameters (name, default, meaning): H_VISIBLE 640, H_FP 16, H_SYNC 96, H_BP 48; V_VISIBLE 480, V_FP 10, V_SYNC 2, V_BP 33 (timing in pixels/lines).
REQ-002 SHALL have parameters NUM_SPRITES 4 (sprite count), SPR_W 32 and SPR_H 32 (texels, powers of two), SCALE_LOG2 3 (texel = 2^SCALE_LOG2 square pixels), ANIM_DIV_LOG2 4 (frames per animation phase = 2^ANIM_DIV_LOG2).
REQ-003 SHALL have parameters TRANSPARENT 6'b000000 (see-through texel code), BG_COLOR 6'b111000 ({b,g,r} background), SYNC_POL 0 (asserted sync level).
REQ-004 SHALL have ports: clk in 1 clock; rst_n in 1 reset, synchronous, active-low.
REQ-005 cfg_we in 1 shadow-register write strobe; cfg_sel in IW=max(1,clog2(NUM_SPRITES)) sprite index; cfg_x in 11 sprite left edge; cfg_y in 10 sprite top edge; cfg_en in 1 sprite enable.
REQ-006 rom_addr out IW+1+clog2(SPR_H)+clog2(SPR_W) texel address {sprite, anim, row, col}; rom_data in 6 {b,g,r} texel, valid the cycle after rom_addr (synchronous ROM).
REQ-007 vga_pmod out 8 = {hsync, b[1], g[1], r[1], vsync, b[0], g[0], r[0]}; frame_tick out 1 one-cycle pulse per frame.

Function
REQ-008 Counters x in 0..H_TOTAL-1, y in 0..V_TOTAL-1 (totals = sums of timing parameters); x increments every cycle, wraps to 0 after H_TOTAL-1 and advances y; y wraps to 0 after V_TOTAL-1.
REQ-009 hsync SHALL equal SYNC_POL when H_VISIBLE+H_FP <= x < H_VISIBLE+H_FP+H_SYNC, else ~SYNC_POL; vsync likewise on y with V parameters.
REQ-010 Pipeline: vga_pmod colour and both syncs SHALL reflect counter value (x,y) exactly 3 cycles after the counters hold it; syncs delayed identically to colour.
REQ-011 Sprite i hits when enabled, sx<=x<sx+(SPR_W<<SCALE_LOG2), sy<=y<sy+(SPR_H<<SCALE_LOG2), compared at 12-bit width (no wrap; sprites partly offscreen are clipped).
REQ-012 Among hitting sprites the lowest index wins; rom_addr = {i, anim, (y-sy)>>SCALE_LOG2, (x-sx)>>SCALE_LOG2}, registered at cycle t+1.
REQ-013 Colour: outside visible area 0; visible with no hit, or winning texel == TRANSPARENT, BG_COLOR (lower-priority sprites not shown); else rom_data.
REQ-014 No hit: rom_addr SHALL hold its previous value.
REQ-015 Anim counter (ANIM_DIV_LOG2+1 bits) SHALL increment on the wrap from (H_TOTAL-1,V_TOTAL-1) to (0,0), wrapping mod 2^(ANIM_DIV_LOG2+1); anim = its MSB.
REQ-016 frame_tick SHALL be high for exactly the cycle the counters hold (0,0).
REQ-017 cfg_we writes {cfg_x,cfg_y,cfg_en} to shadow[cfg_sel]; cfg_sel >= NUM_SPRITES ignored.
REQ-018 Active registers SHALL load from all shadows on the (0,0) wrap edge only; a write on that same edge updates shadow only and takes effect next frame; mid-frame writes never alter the displayed frame.

Reset
REQ-019 With rst_n low at a clk edge: x=y=0, anim counter 0, all shadow/active regs 0 (disabled), pipeline cleared, rom_addr 0, frame_tick 0, vga_pmod = {~SYNC_POL,000,~SYNC_POL,000}.
REQ-020 Reset asserted mid-frame SHALL take effect on the next edge; first frame after release starts at (0,0).

Verification
REQ-021 Defaults, no sprites enabled: hsync low for 96 cycles per 800-cycle line starting at pmod cycle x=656+3; vsync low lines 490-491; visible pixels 6'b111000, blanking 0.
REQ-022 Sprite0 at (100,50), enabled, ROM returns address low bits: pmod at x=100..107,y=50 shows texel col 0; x=108 col 1; x=356 background.
REQ-023 Sprites 0 and 1 overlapping at (200,200), sprite0 texel TRANSPARENT: overlap shows BG_COLOR, never sprite1.
REQ-024 cfg write moving sprite0 mid-frame at y=240: no change this frame; new position from next frame; write issued during the (0,0) cycle: applied one frame later.
REQ-025 Run 32 frames: anim bit in rom_addr 0 for frames 0-15, 1 for 16-31, 0 at frame 32; frame_tick once per 420000 cycles.
REQ-026 rst_n pulsed low at (300,100): next cycles show counters (0,0), all sprites disabled, pmod blank with syncs inactive.
